// File: rtl/jtag_host.sv
// JTAG initiator: runs TAP-reset, IR-scan, DR-scan and idle-clock commands on a
// bit-banged TCK/TMS/TDI/TRST_n port and returns the TDO bits captured while shifting.
module jtag_host #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned MAX_LEN = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [5:0]         cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
    output logic               trst_n,
    input  logic               tdo
);

    localparam int unsigned PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
    localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        OP_RESET = 2'b00,
        OP_IR    = 2'b01,
        OP_DR    = 2'b10,
        OP_IDLE  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_PRE,
        S_SHIFT,
        S_POST,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [PH_W-1:0]    ph_q, ph_d;
    logic [2:0]         seq_q, seq_d;
    logic [LEN_W-1:0]   bit_q, bit_d;
    op_e                op_q, op_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [MAX_LEN-1:0] data_q, data_d;
    logic [MAX_LEN-1:0] cap_q, cap_d;

    logic               tck_d, tms_d, tdi_d, trst_n_d;
    logic               cmd_ready_d, rsp_valid_d;
    logic [MAX_LEN-1:0] rsp_data_d;

    logic               accept, run_tck, tck_end, start_tck, finish;
    logic [LEN_W-1:0]   len_in;

    // Index of the last TCK of the entry sequence (Run-Test/Idle -> Shift-xR, or TLR -> RTI)
    function automatic logic [2:0] pre_last(input op_e op);
        case (op)
            OP_RESET: return 3'd5;
            OP_IR:    return 3'd3;
            default:  return 3'd2;
        endcase
    endfunction

    function automatic logic pre_tms(input op_e op, input logic [2:0] seq);
        case (op)
            OP_RESET: return (seq != 3'd5);
            OP_IR:    return (seq < 3'd2);
            default:  return (seq == 3'd0);
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        seq_d       = seq_q;
        bit_d       = bit_q;
        op_d        = op_q;
        len_d       = len_q;
        data_d      = data_q;
        cap_d       = cap_q;
        tck_d       = tck;
        tms_d       = tms;
        tdi_d       = tdi;
        trst_n_d    = trst_n;
        cmd_ready_d = cmd_ready;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data;
        tck_end     = 1'b0;
        start_tck   = 1'b0;
        finish      = 1'b0;
        accept      = cmd_valid && cmd_ready;

        if (cmd_len == 6'd0) begin
            len_in = LEN_W'(1);
        end else if (32'(cmd_len) > MAX_LEN) begin
            len_in = LEN_W'(MAX_LEN);
        end else begin
            len_in = LEN_W'(cmd_len);
        end

        // TCK phase engine: CLK_DIV cycles low, CLK_DIV high; TDO sampled as TCK rises
        run_tck = (state_q == S_PRE) || (state_q == S_SHIFT) || (state_q == S_POST) ||
                  ((state_q == S_INIT) && trst_n);
        if (run_tck) begin
            if (ph_q != PH_LAST) begin
                ph_d = ph_q + PH_W'(1);
            end else begin
                ph_d = '0;
                if (!tck) begin
                    tck_d = 1'b1;
                    if ((state_q == S_SHIFT) && (op_q != OP_IDLE)) begin
                        cap_d[IDX_W'(bit_q)] = tdo;
                    end
                end else begin
                    tck_d   = 1'b0;
                    tck_end = 1'b1;
                end
            end
        end

        case (state_q)
            S_INIT: begin
                if (!trst_n) begin
                    trst_n_d  = 1'b1;
                    start_tck = 1'b1;
                end else if (tck_end) begin
                    state_d     = S_IDLE;
                    cmd_ready_d = 1'b1;
                    tms_d       = 1'b0;
                end
            end
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    op_d        = op_e'(cmd_op);
                    len_d       = len_in;
                    data_d      = cmd_data;
                    cap_d       = '0;
                    seq_d       = '0;
                    bit_d       = '0;
                    cmd_ready_d = 1'b0;
                    state_d     = (op_e'(cmd_op) == OP_IDLE) ? S_SHIFT : S_PRE;
                    start_tck   = 1'b1;
                end
            end
            S_PRE: begin
                if (tck_end) begin
                    if (seq_q != pre_last(op_q)) begin
                        seq_d     = seq_q + 3'd1;
                        start_tck = 1'b1;
                    end else if (op_q == OP_RESET) begin
                        finish = 1'b1;
                    end else begin
                        state_d   = S_SHIFT;
                        bit_d     = '0;
                        start_tck = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                if (tck_end) begin
                    if (bit_q != LEN_W'(len_q - LEN_W'(1))) begin
                        bit_d     = bit_q + LEN_W'(1);
                        start_tck = 1'b1;
                    end else if (op_q == OP_IDLE) begin
                        finish = 1'b1;
                    end else begin
                        state_d   = S_POST;
                        seq_d     = '0;
                        start_tck = 1'b1;
                    end
                end
            end
            S_POST: begin
                if (tck_end) begin
                    if (seq_q == 3'd0) begin
                        seq_d     = 3'd1;
                        start_tck = 1'b1;
                    end else begin
                        finish = 1'b1;
                    end
                end
            end
            default: state_d = S_INIT;
        endcase

        // Completion: TCK already back low, TAP parked in Run-Test/Idle
        if (finish) begin
            state_d     = S_DONE;
            rsp_valid_d = 1'b1;
            cmd_ready_d = 1'b1;
            rsp_data_d  = cap_q;
            tms_d       = 1'b0;
            tdi_d       = 1'b0;
        end

        // TMS/TDI only move at the start of a TCK's low phase
        if (start_tck) begin
            ph_d  = '0;
            tck_d = 1'b0;
            tdi_d = 1'b0;
            case (state_d)
                S_PRE:   tms_d = pre_tms(op_d, seq_d);
                S_SHIFT: begin
                    tms_d = (op_d != OP_IDLE) && (bit_d == LEN_W'(len_d - LEN_W'(1)));
                    if (op_d != OP_IDLE) begin
                        tdi_d = data_d[IDX_W'(bit_d)];
                    end
                end
                S_POST:  tms_d = (seq_d == 3'd0);
                default: tms_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_INIT;
            ph_q      <= '0;
            seq_q     <= '0;
            bit_q     <= '0;
            op_q      <= OP_RESET;
            len_q     <= '0;
            data_q    <= '0;
            cap_q     <= '0;
            tck       <= 1'b0;
            tms       <= 1'b1;
            tdi       <= 1'b0;
            trst_n    <= 1'b0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            seq_q     <= seq_d;
            bit_q     <= bit_d;
            op_q      <= op_d;
            len_q     <= len_d;
            data_q    <= data_d;
            cap_q     <= cap_d;
            tck       <= tck_d;
            tms       <= tms_d;
            tdi       <= tdi_d;
            trst_n    <= trst_n_d;
            cmd_ready <= cmd_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_data  <= rsp_data_d;
        end
    end

endmodule

// File: doc/jtag_host.md
Name: jtag_host

Overview:
- JTAG initiator: bit-bangs TCK/TMS/TDI/TRST_n and samples TDO to drive an external or on-chip TAP, e.g. the jtag target on ui_in[3:0].
- Accepts one command at a time over a valid/ready interface: TAP reset, IR scan, DR scan, or idle clocks. Returns the captured TDO bits on a one-cycle response strobe.
- Used for on-chip self-test and as a bench driver for the TAP.

Parameters:
- CLK_DIV, 2, clk cycles per TCK half-period (>=1); one TCK period = 2*CLK_DIV clk cycles.
- MAX_LEN, 32, maximum scan length in bits; sets the cmd_data and rsp_data width.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  host idle, can accept a command
- cmd_op  input  2  00=TAP reset, 01=IR scan, 10=DR scan, 11=idle clocks
- cmd_len  input  6  scan length, or idle TCK count
- cmd_data  input  MAX_LEN  TDI bits, LSB shifted first
- rsp_valid  output  1  one-cycle pulse at command completion
- rsp_data  output  MAX_LEN  captured TDO bits, bit i = i-th shifted bit
- tck  output  1  JTAG clock
- tms  output  1  JTAG mode select
- tdi  output  1  JTAG data to TAP
- trst_n  output  1  JTAG TAP reset, active low
- tdo  input  1  JTAG data from TAP

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on rst_n. All state is sampled at posedge clk.
- Reset values: tck=0, tms=1, tdi=0, trst_n=0, cmd_ready=0, rsp_valid=0, rsp_data=0.
- Reset mid-command aborts the command. No rsp_valid is issued.
- Post-reset init: first cycle after rst_n high, trst_n=1. Host then runs 1 TCK with tms=0 (Test-Logic-Reset -> Run-Test/Idle). cmd_ready rises after that TCK completes.
- TCK timing: each TCK is CLK_DIV cycles low, then CLK_DIV cycles high, and tck idles low.
  - tms and tdi change only on the cycle tck goes 1->0, or at the start of the first low phase.
  - tdo is sampled on the clk cycle where tck goes 0->1.
- Handshake: accept when cmd_valid && cmd_ready. cmd_op, cmd_len and cmd_data are latched. cmd_ready=0 from the next cycle until completion.
- Length rules: cmd_len=0 is treated as 1; cmd_len>MAX_LEN is clamped to MAX_LEN.
- Host assumes the TAP is in Run-Test/Idle between commands and always returns it there.
- TMS sequences, one entry per TCK:
  - TAP reset: 1,1,1,1,1,0 (6 TCKs). rsp_data=0.
  - IR scan: 1,1,0,0, then len shift TCKs (tms=0, last one tms=1), then 1,0. Total len+6 TCKs.
  - DR scan: 1,0,0, then len shift TCKs (tms=0, last one tms=1), then 1,0. Total len+5 TCKs.
  - Idle: len TCKs with tms=0. rsp_data=0.
- Shift TCKs: tdi=cmd_data[k] on the k-th shift TCK. tdo sampled at that TCK's rising edge goes to rsp_data[k]. rsp_data bits >= len are 0. tdi=0 outside shift TCKs.
- Completion: after the last TCK's high phase, tck returns low. On that same cycle rsp_valid=1 for exactly one cycle and cmd_ready=1. rsp_data holds until the next completion.
- A new command may be accepted on the rsp_valid cycle. Back-to-back commands insert no extra TCKs.
- Implementation: FSM states INIT, IDLE, PRE, SHIFT, POST, DONE, plus a TCK phase counter (0..CLK_DIV-1), a bit counter (0..MAX_LEN) and a sequence counter for PRE/POST.

Test Plan:
- Reset release, CLK_DIV=2:
  - trst_n=1 at cycle 1; exactly 1 TCK with tms=0.
  - cmd_ready=1 at cycle 5; tck low, tms=0 thereafter.
- IR scan, op=01, len=4, data=0xA, TAP model in Run-Test/Idle:
  - 10 TCKs (40 clk) with tms 1,1,0,0,0,0,0,1,1,0.
  - tdi during shift 0,1,0,1.
  - Model IR captures 0b0001, so rsp_data=0x1 with rsp_valid pulse.
- DR scan after TAP reset, op=10, len=32, data=0, model IDCODE 0x1BEEF0DF:
  - 37 TCKs; rsp_data=0x1BEEF0DF.
  - tms=1 only on TCK 1, on the 32nd shift TCK, and on the following TCK.
- Length edges:
  - len=0 gives a 1-bit DR scan, 6 TCKs.
  - len=40 clamps to 32, 37 TCKs.
  - Idle op with len=3 gives 3 TCKs, tms=0, rsp_data=0.
- Back-to-back: cmd_valid held high with reset then DR scan:
  - Second command accepted on the first rsp_valid cycle.
  - Total 6+37 TCKs with no gap TCK.
  - cmd_valid while busy is ignored.
- rst_n low during the 10th shift TCK of a DR scan:
  - Next cycle tck=0, tms=1, trst_n=0, cmd_ready=0.
  - No rsp_valid; init sequence repeats after release.
